// File: rtl/matmult_pkg.sv
// Shared types and sizing helpers for the N x N matrix-multiply engine.
package matmult_pkg;

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'd0,
        ST_LOAD_B  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } mm_state_t;

    // Full-precision width of one C element: N products of two W-bit operands.
    function automatic int mm_ow(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/matmult_mac.sv
// Time-shared multiply-accumulate unit with operand extension and a registered accumulator.
module matmult_mac #(
    parameter int W  = 8,
    parameter int OW = 17
) (
    input  logic          hz100,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          signed_mode,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [OW-1:0] acc
);

    logic [OW-1:0] acc_q;
    logic [OW-1:0] acc_d;
    logic [OW-1:0] a_ext;
    logic [OW-1:0] b_ext;
    logic [OW-1:0] prod;

    // Modulo-2^OW arithmetic gives the correct two's-complement result once operands are sign-extended.
    always_comb begin
        a_ext = signed_mode ? {{(OW-W){a[W-1]}}, a} : {{(OW-W){1'b0}}, a};
        b_ext = signed_mode ? {{(OW-W){b[W-1]}}, b} : {{(OW-W){1'b0}}, b};
        prod  = a_ext * b_ext;
        acc_d = (clr ? '0 : acc_q) + prod;
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matmult_nxn.sv
// N x N matrix-multiply engine: streams in A then B, computes C = A*B with one MAC, streams out C.
module matmult_nxn
    import matmult_pkg::*;
#(
    parameter  int N  = 2,
    parameter  int W  = 8,
    localparam int OW = mm_ow(N, W)
) (
    input  logic          hz100,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    input  logic          signed_mode,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          calc_done
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int CW = $clog2(N);
    localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    function automatic logic [IW-1:0] flat(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(int'(r) * N + int'(c));
    endfunction

    mm_state_t     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;
    logic          mode_q, mode_d;
    logic          calc_done_q, calc_done_d;
    logic          wr_pend_q, wr_pend_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;

    logic [W-1:0]  a_q [NN];
    logic [W-1:0]  b_q [NN];
    logic [OW-1:0] c_q [NN];

    logic          a_we;
    logic          b_we;
    logic          mac_en;
    logic [W-1:0]  a_op;
    logic [W-1:0]  b_op;
    logic [OW-1:0] mac_acc;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        mode_d      = mode_q;
        calc_done_d = 1'b0;
        wr_pend_d   = 1'b0;
        wr_idx_d    = wr_idx_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        a_we        = 1'b0;
        b_we        = 1'b0;
        mac_en      = 1'b0;

        case (state_q)
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_we = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_LOAD_B;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_we = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        mode_d  = signed_mode;
                        state_d = ST_COMPUTE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                busy   = 1'b1;
                mac_en = 1'b1;
                // The accumulator settles one edge after k==N-1, so the C write trails by a cycle.
                if (k_q == CNT_LAST) begin
                    wr_pend_d = 1'b1;
                    wr_idx_d  = flat(i_q, j_q);
                    k_d       = '0;
                    if (j_q == CNT_LAST) begin
                        j_d = '0;
                        if (i_q == CNT_LAST) begin
                            i_d         = '0;
                            calc_done_d = 1'b1;
                            state_d     = ST_OUTPUT;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_LOAD_A;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD_A;
            end
        endcase
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q     <= ST_LOAD_A;
            idx_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            calc_done_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            calc_done_q <= calc_done_d;
            wr_pend_q   <= wr_pend_d;
            wr_idx_q    <= wr_idx_d;
        end
    end

    always_ff @(posedge hz100) begin
        if (a_we) begin
            a_q[idx_q] <= in_data;
        end
        if (b_we) begin
            b_q[idx_q] <= in_data;
        end
        if (wr_pend_q) begin
            c_q[wr_idx_q] <= mac_acc;
        end
    end

    assign a_op = a_q[flat(i_q, k_q)];
    assign b_op = b_q[flat(k_q, j_q)];

    matmult_mac #(
        .W  (W),
        .OW (OW)
    ) u_mac (
        .hz100       (hz100),
        .reset       (reset),
        .clr         (k_q == '0),
        .en          (mac_en),
        .signed_mode (mode_q),
        .a           (a_op),
        .b           (b_op),
        .acc         (mac_acc)
    );

    assign out_data  = out_valid ? c_q[idx_q] : '0;
    assign calc_done = calc_done_q;

endmodule

// File: doc/matmult_nxn.md
# matmult_nxn

Parametrised N×N matrix-multiply engine: the successor to the fixed 2×2 / 8-bit multiplier behind the SPI front end in `top`. It accepts matrix A and then matrix B as a row-major byte/word stream on a valid/ready input. It computes C = A·B with a single time-shared multiply-accumulate unit and returns C row-major on a valid/ready output. New behaviour over the 2×2 block:
- configurable dimension and element width;
- a signed mode;
- a full-precision output width with no overflow;
- output backpressure.

## Interface
Parameters:
- `N`, 2 — matrix dimension, legal 2..4.
- `W`, 8 — input element width, legal 4..16.
- `OW` (localparam), 2·W + clog2(N) — output element width; never truncates.

Ports:
- `hz100`  in  1  — system clock.
- `reset`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — `in_data` holds an element.
- `in_data`  in  W  — element of A (first N² transfers), then B (next N²), row-major.
- `in_ready`  out  1  — engine accepts an element this cycle.
- `signed_mode`  in  1  — 1 = two's-complement operands and results; 0 = unsigned.
- `out_valid`  out  1  — `out_data` holds a C element.
- `out_data`  out  OW  — C element, row-major.
- `out_ready`  in  1  — consumer accepts `out_data` this cycle.
- `busy`  out  1  — high in COMPUTE and OUTPUT.
- `calc_done`  out  1  — one-cycle pulse when C is complete.

## Operation
- States: LOAD_A → LOAD_B → COMPUTE → OUTPUT → LOAD_A.
- LOAD_A / LOAD_B:
  - `in_ready`=1.
  - A transfer occurs when `in_valid`&`in_ready`; the element is written at index `idx` (0..N²−1) and `idx` increments.
  - After the N²-th transfer, `idx` wraps to 0 and the state advances.
- COMPUTE:
  - `in_ready`=0.
  - Counters i, j, k nest, with k innermost.
  - Each cycle: acc ← (k==0 ? 0 : acc) + A[i][k]·B[k][j].
  - On k==N−1 the sum is written to C[i][j].
  - `signed_mode` is sampled into a register on entry to COMPUTE; changes mid-operation are ignored.
  - Signed mode: operands are sign-extended and products/accumulator are OW-bit two's complement. Unsigned mode: operands are zero-extended.
- OUTPUT:
  - `out_valid`=1 and `out_data`=C[`idx`].
  - A transfer occurs on `out_valid`&`out_ready`; `idx` then increments.
  - After the N²-th transfer: `out_valid` drops and the state returns to LOAD_A with `idx`=0.
- Input in non-load states is ignored and there is no error flag (the `in_ready`=0 contract covers it).
- Reset (any state, including mid-load or mid-compute):
  - state = LOAD_A; `idx`, i, j, k, acc = 0.
  - `in_ready`=1 and all other outputs = 0 on the following cycle.
  - A, B and C storage need not be cleared.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0, `calc_done`=0.
- The last B transfer at edge t puts the engine in COMPUTE from cycle t+1.
- COMPUTE lasts exactly N³ cycles.
- `calc_done` is high for the one cycle in which the state first reads OUTPUT; `out_valid` is high in that same cycle.
- Back-to-back operation: the first A element may be accepted in the cycle after the final C transfer.
- `out_data` holds stable while `out_valid`&!`out_ready`.
- `busy` rises with COMPUTE and falls with the return to LOAD_A.

## Structure
- Package `matmult_pkg`:
  - state enum `mm_state_t`;
  - function `mm_ow(N,W)`, which returns 2·W+clog2(N).
- Sub-module `matmult_mac`:
  - ports: `hz100`, `reset`, `clr`, `en`, `signed_mode`, operands a/b (W), acc (OW);
  - registered accumulator;
  - keeps the extend/multiply logic isolated for synthesis.
- A, B and C are flat register arrays (≤16 entries each); no SRAM macro.

## Test plan
1. **Unsigned 2×2, W=8.** A={81,F1,9E,AB}, B={C3,E7,B3,95} → C={10AC6,100AC,0EFEB,0F219}. C00 exceeds 16 bits, which confirms OW=17. `calc_done` pulses exactly 8 cycles after the last B transfer.
2. **Signed 2×2.** `signed_mode`=1, A={FF,00,00,FF} (−I), B={05,FB,80,7F} → C={1FFFB,00005,00080,1FF81}.
3. **Max magnitude, N=3, unsigned.** All elements FF → all nine C = 2FA03 (OW=18). COMPUTE lasts 27 cycles.
4. **Backpressure.** In test 1, hold `out_ready`=0 for 5 cycles at C[1] → `out_data` stays 100AC, no element is skipped or duplicated, and `in_ready` stays 0 until all four C are drained.
5. **Reset mid-operation.** Assert `reset` in the 3rd COMPUTE cycle → next cycle state is LOAD_A with `in_ready`=1, `busy`=0 and `out_valid`=0. A fresh test-1 load then yields the correct C.
6. **Mode latch and ignored input.** Toggle `signed_mode` during COMPUTE and drive `in_valid`=1 with garbage during COMPUTE/OUTPUT → results match the mode sampled at COMPUTE entry, and the next load starts cleanly at A[0].
